// File: rtl/lsu_pkg.sv
// Shared types, access-size encodings and address decode for the memory-stage LSU.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DM_READ   = 2'd1,
    ST_UART_WAIT = 2'd2,
    ST_UART_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] UART_BASE_DEF = 32'h8000_0000;

  // UART window is the 16-byte block sharing the base's upper 28 bits.
  function automatic logic is_uart(input logic [31:0] addr,
                                   input logic [31:0] base = UART_BASE_DEF);
    return addr[31:4] == base[31:4];
  endfunction

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == F3_H[1:0]) && off[0]) ||
           ((f3[1:0] == F3_W[1:0]) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication/strobe generation and load lane extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic        ld_unsigned;

  // Size decode drives both directions; anything not B/H is handled as a word.
  always_comb begin
    ld_shift    = ld_raw >> {off, 3'b000};
    ld_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
    st_wdata    = st_data;
    st_strb     = 4'b1111;
    ld_data     = ld_raw;
    case (funct3[1:0])
      F3_B[1:0]: begin
        st_wdata = {4{st_data[7:0]}};
        st_strb  = 4'b0001 << off;
        ld_data  = ld_unsigned ? {24'b0, ld_shift[7:0]}
                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
      end
      F3_H[1:0]: begin
        st_wdata = {2{st_data[15:0]}};
        st_strb  = 4'b0011 << off;
        ld_data  = ld_unsigned ? {16'b0, ld_shift[15:0]}
                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: DM / UART decode, alignment, stall control and MEM/WB register.
// Handshake: uart_req is held high from UART_WAIT entry through the cycle where uart_ack is
// seen (inclusive); uart_addr/uart_we/uart_wdata are stable over that window. dm_rdata is
// sampled in the cycle after dm_re. Upstream holds its outputs while stall_lsu is high.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        register_write_enable_memory,
  input  logic        dm_mem_write_memory,
  input  logic        dm_mem_read_memory,
  input  logic [1:0]  wb_sel_mw,
  input  logic [31:0] alu_result_mw,
  input  logic [31:0] rs2_data_mw,
  input  logic [2:0]  funct3_mw,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  output logic        dm_we,
  output logic        dm_re,
  input  logic [31:0] dm_rdata,
  output logic        uart_req,
  output logic        uart_we,
  output logic [3:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic        uart_ack,
  input  logic [31:0] uart_rdata,
  output logic        stall_lsu,
  output logic        register_write_enable_wb,
  output logic [1:0]  wb_sel_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] load_data_wb,
  output logic        misaligned_exc,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d;
  logic             rwe_q, rwe_d;
  logic [1:0]       wbsel_q, wbsel_d;
  logic             uwe_q, uwe_d;
  logic [31:0]      uwdata_q, uwdata_d;
  logic [31:0]      udata_q, udata_d;
  logic             rwe_wb_q, rwe_wb_d;
  logic [1:0]       wbsel_wb_q, wbsel_wb_d;
  logic [31:0]      alu_wb_q, alu_wb_d;
  logic [31:0]      ld_wb_q, ld_wb_d;

  logic        access, misal, go, uart_hit, idle;
  logic        dm_we_c, dm_re_c, stall_c, misal_c, bus_err_c;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [31:0] al_st_wdata, al_ld_raw, al_ld_data;
  logic [3:0]  al_st_strb;

  // Decode of the incoming access; both read and write high counts as a write.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    access   = dm_mem_read_memory | dm_mem_write_memory;
    uart_hit = is_uart(alu_result_mw, UART_BASE);
    misal    = access & is_misaligned(funct3_mw, alu_result_mw[1:0]);
    go       = idle & access & ~misal;
    // IDLE aligns the live request; later states align the latched one.
    al_f3    = idle ? funct3_mw : f3_q;
    al_off   = idle ? alu_result_mw[1:0] : addr_q[1:0];
    al_ld_raw = (state_q == ST_DM_READ) ? dm_rdata : uart_rdata;
  end

  lsu_align u_align (
    .funct3   (al_f3),
    .off      (al_off),
    .st_data  (rs2_data_mw),
    .st_wdata (al_st_wdata),
    .st_strb  (al_st_strb),
    .ld_raw   (al_ld_raw),
    .ld_data  (al_ld_data)
  );

  // Next-state, request latching and MEM/WB register update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    rwe_d      = rwe_q;
    wbsel_d    = wbsel_q;
    uwe_d      = uwe_q;
    uwdata_d   = uwdata_q;
    udata_d    = udata_q;
    rwe_wb_d   = rwe_wb_q;
    wbsel_wb_d = wbsel_wb_q;
    alu_wb_d   = alu_wb_q;
    ld_wb_d    = ld_wb_q;
    dm_we_c    = 1'b0;
    dm_re_c    = 1'b0;
    stall_c    = 1'b0;
    misal_c    = 1'b0;
    bus_err_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        misal_c = misal;
        if (go) begin
          f3_d    = funct3_mw;
          addr_d  = alu_result_mw;
          rwe_d   = register_write_enable_memory;
          wbsel_d = wb_sel_mw;
          if (uart_hit) begin
            stall_c  = 1'b1;
            uwe_d    = dm_mem_write_memory;
            uwdata_d = al_st_wdata;
            state_d  = ST_UART_WAIT;
          end else if (dm_mem_write_memory) begin
            dm_we_c = 1'b1;
          end else begin
            dm_re_c = 1'b1;
            stall_c = 1'b1;
            state_d = ST_DM_READ;
          end
        end
        // Single-cycle ops retire here; non-loads write zero load data.
        if (!stall_c) begin
          rwe_wb_d   = register_write_enable_memory & ~misal;
          wbsel_wb_d = wb_sel_mw;
          alu_wb_d   = alu_result_mw;
          ld_wb_d    = '0;
        end
      end
      ST_DM_READ: begin
        rwe_wb_d   = rwe_q;
        wbsel_wb_d = wbsel_q;
        alu_wb_d   = addr_q;
        ld_wb_d    = al_ld_data;
        state_d    = ST_IDLE;
      end
      ST_UART_WAIT: begin
        stall_c = 1'b1;
        if (uart_ack) begin
          udata_d = uwe_q ? 32'b0 : al_ld_data;
          state_d = ST_UART_DONE;
        end else if (cnt_q == CNT_LAST) begin
          udata_d   = '0;
          bus_err_c = 1'b1;
          state_d   = ST_UART_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UART_DONE: begin
        rwe_wb_d   = rwe_q;
        wbsel_wb_d = wbsel_q;
        alu_wb_d   = addr_q;
        ld_wb_d    = udata_q;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and pipeline registers; reset clears everything including the MEM/WB register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      addr_q     <= '0;
      rwe_q      <= 1'b0;
      wbsel_q    <= '0;
      uwe_q      <= 1'b0;
      uwdata_q   <= '0;
      udata_q    <= '0;
      rwe_wb_q   <= 1'b0;
      wbsel_wb_q <= '0;
      alu_wb_q   <= '0;
      ld_wb_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      rwe_q      <= rwe_d;
      wbsel_q    <= wbsel_d;
      uwe_q      <= uwe_d;
      uwdata_q   <= uwdata_d;
      udata_q    <= udata_d;
      rwe_wb_q   <= rwe_wb_d;
      wbsel_wb_q <= wbsel_wb_d;
      alu_wb_q   <= alu_wb_d;
      ld_wb_q    <= ld_wb_d;
    end
  end

  // Combinational strobes are masked while reset is asserted so every output reads 0.
  always_comb begin
    dm_we          = reset & dm_we_c;
    dm_re          = reset & dm_re_c;
    dm_addr        = (dm_we | dm_re) ? alu_result_mw : 32'b0;
    dm_wdata       = dm_we ? al_st_wdata : 32'b0;
    dm_wstrb       = dm_we ? al_st_strb : 4'b0;
    stall_lsu      = reset & stall_c;
    misaligned_exc = reset & misal_c;
    bus_err        = reset & bus_err_c;
    uart_req       = (state_q == ST_UART_WAIT);
    uart_we        = uart_req & uwe_q;
    uart_addr      = uart_req ? addr_q[3:0] : 4'b0;
    uart_wdata     = uart_req ? uwdata_q : 32'b0;
    register_write_enable_wb = rwe_wb_q;
    wb_sel_wb      = wbsel_wb_q;
    alu_result_wb  = alu_wb_q;
    load_data_wb   = ld_wb_q;
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table for single DM accesses plus UART/reset sequences.
module tb_lsu_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        rwe, wr, rd;
  logic [1:0]  wb_sel;
  logic [31:0] addr, rs2;
  logic [2:0]  f3;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        dm_we, dm_re;
  logic        uart_req, uart_we, uart_ack;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata, uart_rdata;
  logic        stall_lsu, rwe_wb, misaligned_exc, bus_err;
  logic [1:0]  wb_sel_wb, state_dbg;
  logic [31:0] alu_wb, ld_wb;

  lsu_mem_stage #(.UART_BASE(32'h8000_0000), .TIMEOUT(4)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .register_write_enable_memory (rwe),
    .dm_mem_write_memory          (wr),
    .dm_mem_read_memory           (rd),
    .wb_sel_mw                    (wb_sel),
    .alu_result_mw                (addr),
    .rs2_data_mw                  (rs2),
    .funct3_mw                    (f3),
    .dm_addr                      (dm_addr),
    .dm_wdata                     (dm_wdata),
    .dm_wstrb                     (dm_wstrb),
    .dm_we                        (dm_we),
    .dm_re                        (dm_re),
    .dm_rdata                     (dm_rdata),
    .uart_req                     (uart_req),
    .uart_we                      (uart_we),
    .uart_addr                    (uart_addr),
    .uart_wdata                   (uart_wdata),
    .uart_ack                     (uart_ack),
    .uart_rdata                   (uart_rdata),
    .stall_lsu                    (stall_lsu),
    .register_write_enable_wb     (rwe_wb),
    .wb_sel_wb                    (wb_sel_wb),
    .alu_result_wb                (alu_wb),
    .load_data_wb                 (ld_wb),
    .misaligned_exc               (misaligned_exc),
    .bus_err                      (bus_err),
    .state_dbg                    (state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        rd, wr, rwe;
    logic [1:0]  wb_sel;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    logic        e_we, e_re, e_stall, e_misal;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_rwe_wb;
    logic [31:0] e_ld;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  vec_t v;
  int   stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_nop();
    rd = 1'b0; wr = 1'b0; rwe = 1'b0; wb_sel = 2'b00;
    addr = 32'h0; rs2 = 32'h0; f3 = 3'b000;
  endtask

  initial begin
    //            rd  wr  rwe wbs  f3      addr          rs2           rdata          we  re  st  mis strb     wdata         rwb  ld
    vecs[0]  = '{1'b0,1'b1,1'b0,2'd0,3'b000,32'h0000_0102,32'h0000_00A5,32'h0,        1'b1,1'b0,1'b0,1'b0,4'b0100,32'hA5A5_A5A5,1'b0,32'h0};
    vecs[1]  = '{1'b0,1'b1,1'b0,2'd0,3'b001,32'h0000_0206,32'h1234_BEEF,32'h0,        1'b1,1'b0,1'b0,1'b0,4'b1100,32'hBEEF_BEEF,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0,2'd0,3'b010,32'h0000_0300,32'hDEAD_BEEF,32'h0,        1'b1,1'b0,1'b0,1'b0,4'b1111,32'hDEAD_BEEF,1'b0,32'h0};
    vecs[3]  = '{1'b1,1'b1,1'b0,2'd0,3'b010,32'h0000_0500,32'h0102_0304,32'h0,        1'b1,1'b0,1'b0,1'b0,4'b1111,32'h0102_0304,1'b0,32'h0};
    vecs[4]  = '{1'b0,1'b0,1'b1,2'd0,3'b000,32'h1234_5678,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b1,32'h0};
    vecs[5]  = '{1'b1,1'b0,1'b1,2'd1,3'b001,32'h0000_0202,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'hFFFF_80FF};
    vecs[6]  = '{1'b1,1'b0,1'b1,2'd1,3'b101,32'h0000_0202,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'h0000_80FF};
    vecs[7]  = '{1'b1,1'b0,1'b1,2'd1,3'b000,32'h0000_0103,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'hFFFF_FF80};
    vecs[8]  = '{1'b1,1'b0,1'b1,2'd1,3'b100,32'h0000_0101,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'h0000_0012};
    vecs[9]  = '{1'b1,1'b0,1'b1,2'd1,3'b000,32'h0000_0102,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'hFFFF_FFFF};
    vecs[10] = '{1'b1,1'b0,1'b1,2'd1,3'b010,32'h0000_0400,32'h0,        32'hCAFE_F00D,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'hCAFE_F00D};
    vecs[11] = '{1'b1,1'b0,1'b1,2'd1,3'b010,32'h0000_0101,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,4'b0000,32'h0,        1'b0,32'h0};
    vecs[12] = '{1'b0,1'b1,1'b0,2'd0,3'b001,32'h0000_0203,32'h0000_FFFF,32'h0,        1'b0,1'b0,1'b0,1'b1,4'b0000,32'h0,        1'b0,32'h0};
    vecs[13] = '{1'b1,1'b0,1'b1,2'd1,3'b101,32'h0000_0200,32'h0,        32'h80FF_1234,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0,        1'b1,32'h0000_1234};

    // Reset with a store presented: everything must read 0.
    reset = 1'b0;
    drive_nop();
    dm_rdata = 32'h0; uart_ack = 1'b0; uart_rdata = 32'h0;
    wr = 1'b1; addr = 32'h100; f3 = 3'b010; rs2 = 32'h1234_5678;
    #23;
    chk("rst dm_we", dm_we, 1'b0);
    chk("rst dm_wstrb", dm_wstrb, 4'h0);
    chk("rst dm_wdata", dm_wdata, 32'h0);
    chk("rst stall", stall_lsu, 1'b0);
    chk("rst uart_req", uart_req, 1'b0);
    chk("rst rwe_wb", rwe_wb, 1'b0);
    chk("rst ld_wb", ld_wb, 32'h0);
    chk("rst state", state_dbg, 2'd0);
    drive_nop();
    reset = 1'b1;
    step();

    // Single DM accesses from the table.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      rd = v.rd; wr = v.wr; rwe = v.rwe; wb_sel = v.wb_sel;
      f3 = v.f3; addr = v.addr; rs2 = v.rs2; dm_rdata = 32'h0;
      exp_q.push_back(v.e_ld);
      #1;
      chk($sformatf("v%0d dm_we", i), dm_we, v.e_we);
      chk($sformatf("v%0d dm_re", i), dm_re, v.e_re);
      chk($sformatf("v%0d dm_wstrb", i), dm_wstrb, v.e_strb);
      chk($sformatf("v%0d dm_wdata", i), dm_wdata, v.e_wdata);
      chk($sformatf("v%0d dm_addr", i), dm_addr, (v.e_we | v.e_re) ? v.addr : 32'h0);
      chk($sformatf("v%0d stall", i), stall_lsu, v.e_stall);
      chk($sformatf("v%0d misaligned", i), misaligned_exc, v.e_misal);
      if (v.e_stall) begin
        step();
        dm_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d dm_read stall", i), stall_lsu, 1'b0);
        chk($sformatf("v%0d dm_read state", i), state_dbg, 2'd1);
      end
      step();
      drive_nop();
      dm_rdata = 32'h0;
      #1;
      chk($sformatf("v%0d rwe_wb", i), rwe_wb, v.e_rwe_wb);
      chk($sformatf("v%0d wb_sel_wb", i), wb_sel_wb, v.wb_sel);
      chk($sformatf("v%0d alu_wb", i), alu_wb, v.addr);
      chk($sformatf("v%0d ld_wb", i), ld_wb, exp_q.pop_front());
      chk($sformatf("v%0d misaligned after", i), misaligned_exc, 1'b0);
      chk($sformatf("v%0d state after", i), state_dbg, 2'd0);
    end

    // UART LW, ack on the third wait cycle.
    rd = 1'b1; rwe = 1'b1; wb_sel = 2'd1; f3 = 3'b010; addr = 32'h8000_0004;
    #1;
    stall_cnt = 0;
    chk("u_lw dm_re", dm_re, 1'b0);
    chk("u_lw req idle", uart_req, 1'b0);
    if (stall_lsu) stall_cnt++;
    step();
    for (int w = 1; w <= 3; w++) begin
      if (w == 3) begin uart_ack = 1'b1; uart_rdata = 32'h0000_005A; end
      #1;
      chk($sformatf("u_lw req w%0d", w), uart_req, 1'b1);
      chk($sformatf("u_lw addr w%0d", w), uart_addr, 4'd4);
      chk($sformatf("u_lw we w%0d", w), uart_we, 1'b0);
      if (stall_lsu) stall_cnt++;
      step();
    end
    uart_ack = 1'b0; uart_rdata = 32'h0;
    #1;
    chk("u_lw done state", state_dbg, 2'd3);
    chk("u_lw done req", uart_req, 1'b0);
    chk("u_lw done stall", stall_lsu, 1'b0);
    step();
    drive_nop();
    #1;
    chk("u_lw ld_wb", ld_wb, 32'h0000_005A);
    chk("u_lw rwe_wb", rwe_wb, 1'b1);
    chk("u_lw alu_wb", alu_wb, 32'h8000_0004);
    chk("u_lw stall cycles", stall_cnt, 4);

    // UART LB at offset 2, ack on the first wait cycle, sign-extended.
    rd = 1'b1; rwe = 1'b1; wb_sel = 2'd1; f3 = 3'b000; addr = 32'h8000_0006;
    #1;
    chk("u_lb stall idle", stall_lsu, 1'b1);
    step();
    uart_ack = 1'b1; uart_rdata = 32'h00AB_0000;
    #1;
    chk("u_lb addr", uart_addr, 4'd6);
    step();
    uart_ack = 1'b0; uart_rdata = 32'h0;
    #1;
    chk("u_lb done stall", stall_lsu, 1'b0);
    step();
    drive_nop();
    #1;
    chk("u_lb ld_wb", ld_wb, 32'hFFFF_FFAB);

    // UART SW with no ack: timeout after 4 wait cycles.
    wr = 1'b1; f3 = 3'b010; addr = 32'h8000_0008; rs2 = 32'h1122_3344;
    #1;
    chk("u_to stall idle", stall_lsu, 1'b1);
    chk("u_to dm_we", dm_we, 1'b0);
    step();
    for (int w = 1; w <= 4; w++) begin
      chk($sformatf("u_to req w%0d", w), uart_req, 1'b1);
      chk($sformatf("u_to we w%0d", w), uart_we, 1'b1);
      chk($sformatf("u_to wdata w%0d", w), uart_wdata, 32'h1122_3344);
      chk($sformatf("u_to addr w%0d", w), uart_addr, 4'd8);
      chk($sformatf("u_to stall w%0d", w), stall_lsu, 1'b1);
      chk($sformatf("u_to bus_err w%0d", w), bus_err, (w == 4) ? 32'h1 : 32'h0);
      step();
    end
    chk("u_to done bus_err", bus_err, 1'b0);
    chk("u_to done stall", stall_lsu, 1'b0);
    chk("u_to done req", uart_req, 1'b0);
    step();
    drive_nop();
    #1;
    chk("u_to ld_wb", ld_wb, 32'h0);
    chk("u_to rwe_wb", rwe_wb, 1'b0);

    // Stray ack while idle is ignored.
    uart_ack = 1'b1; uart_rdata = 32'h1234_5678;
    rwe = 1'b1; addr = 32'h55;
    step();
    uart_ack = 1'b0; uart_rdata = 32'h0;
    #1;
    chk("stray state", state_dbg, 2'd0);
    chk("stray rwe_wb", rwe_wb, 1'b1);
    chk("stray alu_wb", alu_wb, 32'h55);
    chk("stray ld_wb", ld_wb, 32'h0);

    // Reset asserted during UART_WAIT.
    rd = 1'b1; rwe = 1'b1; wb_sel = 2'd1; f3 = 3'b010; addr = 32'h8000_0000;
    step();
    chk("rmid req w1", uart_req, 1'b1);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("rmid req", uart_req, 1'b0);
    chk("rmid stall", stall_lsu, 1'b0);
    chk("rmid state", state_dbg, 2'd0);
    chk("rmid rwe_wb", rwe_wb, 1'b0);
    chk("rmid alu_wb", alu_wb, 32'h0);
    chk("rmid dm_re", dm_re, 1'b0);
    drive_nop();
    step();
    step();
    reset = 1'b1;
    uart_ack = 1'b1; uart_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late ack req", uart_req, 1'b0);
    step();
    step();
    chk("late ack state", state_dbg, 2'd0);
    chk("late ack ld_wb", ld_wb, 32'h0);
    chk("late ack rwe_wb", rwe_wb, 1'b0);
    chk("late ack stall", stall_lsu, 1'b0);
    uart_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
